// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding and common host command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        DATA,
        PARITY,
        STOP,
        ACK,
        RELEASE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and open-drain PS/2 pin signals of the host transmitter.
interface ps2_host_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport slave (
        input  tx_start, tx_data, ps2_clk_i, ps2_data_i,
        output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );

    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_done, tx_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the PS/2 pins and debounces the clock line into a one-cycle falling-edge pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clk_pin,
    input  logic i_data_pin,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       r_clk_meta;
    logic [1:0]       r_data_meta;
    logic             r_clk_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fall;
    logic             w_clk_sync;

    assign w_clk_sync = r_clk_meta[1];

    // A new clock level is accepted only after FILTER_LEN consecutive samples disagree with the old one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_meta  <= 2'b11;
            r_data_meta <= 2'b11;
            r_clk_level <= 1'b1;
            r_cnt       <= '0;
            r_fall      <= 1'b0;
        end else begin
            r_clk_meta  <= {r_clk_meta[0], i_clk_pin};
            r_data_meta <= {r_data_meta[0], i_data_pin};
            r_fall      <= 1'b0;
            if (w_clk_sync == r_clk_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_clk_level <= w_clk_sync;
                r_cnt       <= '0;
                r_fall      <= ~w_clk_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_sync  = w_clk_sync;
    assign o_data_sync = r_data_meta[1];
    assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, then shifts one byte
// out on device-generated clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_END  = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    r_state;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_clk_oe;
    logic             r_data_oe;

    logic w_clk_sync;
    logic w_data_sync;
    logic w_fall;
    logic w_timeout;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk         (clk),
        .rst         (rst),
        .i_clk_pin   (bus.ps2_clk_i),
        .i_data_pin  (bus.ps2_data_i),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_fall      (w_fall)
    );

    assign w_timeout = (r_cnt == TMO_LAST) && !w_fall;

    // One counter serves both the inhibit interval and the inter-edge timeout, since they never overlap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (bus.tx_start) begin
                        r_shift   <= bus.tx_data;
                        r_parity  <= odd_parity(bus.tx_data);
                        r_bit_cnt <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                    end
                    if (r_cnt == INH_END) begin
                        r_clk_oe <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= DATA;
                    end
                end
                default: begin
                    if (w_fall) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_state == RELEASE) begin
                        if (w_clk_sync && w_data_sync) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (w_fall) begin
                        // Pulling data low sends a 0, so the enable is the inverted bit.
                        case (r_state)
                            DATA: begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                if (r_bit_cnt == 3'd7) begin
                                    r_state <= PARITY;
                                end
                            end
                            PARITY: begin
                                r_data_oe <= ~r_parity;
                                r_state   <= STOP;
                            end
                            STOP: begin
                                r_data_oe <= 1'b0;
                                r_state   <= ACK;
                            end
                            ACK: begin
                                if (!w_data_sync) begin
                                    r_state <= RELEASE;
                                end else begin
                                    r_err     <= 1'b1;
                                    r_busy    <= 1'b0;
                                    r_clk_oe  <= 1'b0;
                                    r_data_oe <= 1'b0;
                                    r_state   <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.tx_busy     = r_busy;
    assign bus.tx_done     = r_done;
    assign bus.tx_err      = r_err;
    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// checks bits, parity, ACK handling, timeout, reset and busy behaviour.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TMO  = 400;
    localparam int FLEN = 4;
    localparam int HALF = 30;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         expParity;
        bit         expDone;
        bit         expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic devClkLow = 1'b0;
    logic devDataLow = 1'b0;
    bit   devActive = 1'b0;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int errCount = 0;
    int busViolations = 0;
    int parityMismatch = 0;

    vec_t vecs[5];

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.ps2_clk_i  = ~(bus.ps2_clk_oe | devClkLow);
    assign bus.ps2_data_i = ~(bus.ps2_data_oe | devDataLow);

    // Pulse counters and the rule that the host never holds the clock while the device clocks.
    always @(negedge clk) begin
        if (bus.tx_done) doneCount++;
        if (bus.tx_err) errCount++;
        if (devActive && bus.ps2_clk_oe) busViolations++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic startTransfer(input logic [7:0] data);
        bus.tx_data  = data;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        checkOutput("accept_busy", 32'(bus.tx_busy), 32'd1);
        checkOutput("accept_clk_oe", 32'(bus.ps2_clk_oe), 32'd1);
        checkOutput("accept_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        repeat (INH - 1) tick();
        checkOutput("inhibit_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        tick();
        checkOutput("start_bit_data_oe", 32'(bus.ps2_data_oe), 32'd1);
        checkOutput("start_bit_clk_oe", 32'(bus.ps2_clk_oe), 32'd1);
        tick();
        checkOutput("clk_release", 32'(bus.ps2_clk_oe), 32'd0);
        checkOutput("start_bit_held", 32'(bus.ps2_data_oe), 32'd1);
    endtask

    // Device side: sample the data line on each rising clock, optionally pull data low for ACK.
    task automatic deviceClock(input int nFalls, input bit ack, output logic [10:0] line);
        line = '1;
        devActive = 1'b1;
        repeat (HALF) tick();
        checkOutput("start_bit_on_line", 32'(bus.ps2_data_i), 32'd0);
        for (int i = 0; i < nFalls; i++) begin
            if (i == 10) devDataLow = ack;
            devClkLow = 1'b1;
            repeat (HALF) tick();
            devClkLow = 1'b0;
            line[i] = bus.ps2_data_i;
            repeat (HALF) tick();
        end
        devDataLow = 1'b0;
        devActive = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.tx_busy && n < 2000) begin
            tick();
            n++;
        end
        checkOutput({name, "_finished"}, 32'(n < 2000), 32'd1);
        checkOutput({name, "_end_pulse_with_idle"}, 32'(bus.tx_done | bus.tx_err), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [10:0] line, output int dDone, output int dErr);
        int d0 = doneCount;
        int e0 = errCount;
        startTransfer(v.data);
        fork
            deviceClock(11, v.ack, line);
            waitIdle("frame");
        join
        tick();
        dDone = doneCount - d0;
        dErr  = errCount - e0;
    endtask

    task automatic checkFrame(input vec_t v, input logic [10:0] line, input int dDone, input int dErr);
        if (^line[8:0] !== 1'b1) parityMismatch++;
        checkOutput($sformatf("frame_%02h_byte", v.data), 32'(line[7:0]), 32'(v.data));
        checkOutput($sformatf("frame_%02h_parity", v.data), 32'(line[8]), 32'(v.expParity));
        checkOutput($sformatf("frame_%02h_stop", v.data), 32'(line[9]), 32'd1);
        checkOutput($sformatf("frame_%02h_done", v.data), 32'(dDone), 32'(v.expDone));
        checkOutput($sformatf("frame_%02h_err", v.data), 32'(dErr), 32'(v.expErr));
        checkOutput($sformatf("frame_%02h_busy", v.data), 32'(bus.tx_busy), 32'd0);
        checkOutput($sformatf("frame_%02h_oes", v.data), 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] line;
        int          dDone;
        int          dErr;
        int          e0;
        int          d0;
        vec_t        v;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset_outputs", 32'({bus.tx_busy, bus.tx_done, bus.tx_err, bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("idle_outputs", 32'({bus.tx_busy, bus.tx_done, bus.tx_err, bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], line, dDone, dErr);
            checkFrame(vecs[i], line, dDone, dErr);
        end

        // Device stops after bit 3; error must land exactly TMO cycles after the fourth fall is seen.
        startTransfer(8'h07);
        deviceClock(3, 1'b0, line);
        e0 = errCount;
        devActive = 1'b1;
        devClkLow = 1'b1;
        for (int k = 1; k <= FLEN + 3 + TMO; k++) begin
            tick();
            if (k == HALF) devClkLow = 1'b0;
            if (k == FLEN + 2 + TMO) begin
                checkOutput("timeout_not_early", 32'(bus.tx_err), 32'd0);
                checkOutput("timeout_no_prior_err", 32'(errCount - e0), 32'd0);
                checkOutput("timeout_bit3_driven", 32'(bus.ps2_data_oe), 32'd1);
            end
        end
        checkOutput("timeout_err", 32'(bus.tx_err), 32'd1);
        checkOutput("timeout_busy", 32'(bus.tx_busy), 32'd0);
        checkOutput("timeout_oes", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
        devActive = 1'b0;
        repeat (5) tick();

        // Reset in the middle of the data bits, then a clean echo command.
        startTransfer(8'h1F);
        deviceClock(6, 1'b0, line);
        checkOutput("pre_reset_data_oe", 32'(bus.ps2_data_oe), 32'd1);
        checkOutput("pre_reset_busy", 32'(bus.tx_busy), 32'd1);
        rst = 1'b0;
        tick();
        checkOutput("mid_reset_oes", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
        checkOutput("mid_reset_busy", 32'(bus.tx_busy), 32'd0);
        rst = 1'b1;
        repeat (5) tick();
        v = '{CMD_ECHO, 1'b1, 1'b1, 1'b1, 1'b0};
        applyStimulus(v, line, dDone, dErr);
        checkFrame(v, line, dDone, dErr);

        // A second request while busy must be dropped, not queued.
        d0 = doneCount;
        e0 = errCount;
        startTransfer(CMD_SET_LEDS);
        fork
            deviceClock(11, 1'b1, line);
            waitIdle("ignore");
            begin
                repeat (5 * 2 * HALF) tick();
                bus.tx_data  = 8'h55;
                bus.tx_start = 1'b1;
                tick();
                bus.tx_start = 1'b0;
                bus.tx_data  = CMD_SET_LEDS;
            end
        join
        tick();
        v = '{CMD_SET_LEDS, 1'b1, 1'b1, 1'b1, 1'b0};
        checkFrame(v, line, doneCount - d0, errCount - e0);
        repeat (20) tick();
        checkOutput("ignored_start_busy", 32'(bus.tx_busy), 32'd0);
        checkOutput("ignored_start_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        checkOutput("ignored_start_done_total", 32'(doneCount - d0), 32'd1);

        checkOutput("bus_rule_violations", 32'(busViolations), 32'd0);
        checkOutput("parity_mismatches", 32'(parityMismatch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
